cmul_pipe: RTL and testbench

Parametrised, pipelined complex multiplier with a valid/ready stream interface and per-transaction conjugate mode. It computes (a + jb)·(c ± jd), then applies a programmable right-shift with round-half-up and saturates to a configurable output width. A sideband tag travels with each sample. It replaces the fixed 16-bit free-running multiplier in the datapath wherever flow control, scaling or conjugation is needed.

---
 rtl/cmul_pipe_if.sv | 33 +++
 rtl/cmul_pipe.sv | 163 ++++++++++++++++
 tb/tb_cmul_pipe.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmul_pipe_if.sv
// Stream interface for cmul_pipe: input operands/tag with valid/ready,
// result components/saturation flags/tag with valid/ready.
interface cmul_pipe_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int TAG_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic signed [DATA_W-1:0] in_c;
  logic signed [DATA_W-1:0] in_d;
  logic                     in_conj;
  logic [TAG_W-1:0]         in_tag;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_re;
  logic signed [OUT_W-1:0]  out_im;
  logic [1:0]               out_sat;
  logic [TAG_W-1:0]         out_tag;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_conj, in_tag, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sat, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_conj, in_tag, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sat, out_tag
  );
endinterface

// File: rtl/cmul_pipe.sv
// Four-stage pipelined complex multiplier (a+jb)(c+/-jd) with round-half-up
// right shift, output saturation and a tag carried alongside each sample.
module cmul_pipe #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0,
  parameter int TAG_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cmul_pipe_if.slave    bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + 1;
  // One extra bit over the sum so adding the rounding constant never wraps.
  localparam int RND_W  = SUM_W + 1;

  localparam logic signed [RND_W-1:0] ONE   = {{(RND_W-1){1'b0}}, 1'b1};
  localparam logic signed [RND_W-1:0] RND   = (ONE <<< SHIFT) >>> 1;
  localparam logic signed [RND_W-1:0] MAX_V = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [RND_W-1:0] MIN_V = -MAX_V - ONE;

  logic stall;

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_a, s1_b, s1_c, s1_d;
  logic                     s1_conj;
  logic [TAG_W-1:0]         s1_tag;

  logic                     s2_valid;
  logic signed [PROD_W-1:0] s2_ac, s2_bd, s2_bc, s2_ad;
  logic                     s2_conj;
  logic [TAG_W-1:0]         s2_tag;

  logic                     s3_valid;
  logic signed [SUM_W-1:0]  s3_re, s3_im;
  logic [TAG_W-1:0]         s3_tag;

  logic                     s4_valid;
  logic signed [OUT_W-1:0]  s4_re, s4_im;
  logic [1:0]               s4_sat;
  logic [TAG_W-1:0]         s4_tag;

  logic signed [PROD_W-1:0] ax, bx, cx, dx;
  logic signed [SUM_W-1:0]  ac_x, bd_x, bc_x, ad_x;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic [OUT_W:0]           rs_re, rs_im;

  // Whole pipe freezes only when a result is waiting and nobody takes it.
  assign stall        = s4_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  function automatic logic [OUT_W:0] round_sat(input logic signed [SUM_W-1:0] s);
    logic signed [RND_W-1:0] r;
    r = $signed({s[SUM_W-1], s}) + RND;
    r = r >>> SHIFT;
    if (r > MAX_V) begin
      return {1'b1, MAX_V[OUT_W-1:0]};
    end else if (r < MIN_V) begin
      return {1'b1, MIN_V[OUT_W-1:0]};
    end else begin
      return {1'b0, r[OUT_W-1:0]};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a    <= bus.in_a;
        s1_b    <= bus.in_b;
        s1_c    <= bus.in_c;
        s1_d    <= bus.in_d;
        s1_conj <= bus.in_conj;
        s1_tag  <= bus.in_tag;
      end
    end
  end

  always_comb begin
    ax = {{DATA_W{s1_a[DATA_W-1]}}, s1_a};
    bx = {{DATA_W{s1_b[DATA_W-1]}}, s1_b};
    cx = {{DATA_W{s1_c[DATA_W-1]}}, s1_c};
    dx = {{DATA_W{s1_d[DATA_W-1]}}, s1_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ac   <= ax * cx;
        s2_bd   <= bx * dx;
        s2_bc   <= bx * cx;
        s2_ad   <= ax * dx;
        s2_conj <= s1_conj;
        s2_tag  <= s1_tag;
      end
    end
  end

  always_comb begin
    ac_x = {s2_ac[PROD_W-1], s2_ac};
    bd_x = {s2_bd[PROD_W-1], s2_bd};
    bc_x = {s2_bc[PROD_W-1], s2_bc};
    ad_x = {s2_ad[PROD_W-1], s2_ad};
    if (s2_conj) begin
      sum_re = ac_x + bd_x;
      sum_im = bc_x - ad_x;
    end else begin
      sum_re = ac_x - bd_x;
      sum_im = bc_x + ad_x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_re  <= sum_re;
        s3_im  <= sum_im;
        s3_tag <= s2_tag;
      end
    end
  end

  always_comb begin
    rs_re = round_sat(s3_re);
    rs_im = round_sat(s3_im);
  end

  // Output data only changes on a real sample, so bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s4_valid <= 1'b0;
      s4_re    <= '0;
      s4_im    <= '0;
      s4_sat   <= '0;
      s4_tag   <= '0;
    end else if (!stall) begin
      s4_valid <= s3_valid;
      if (s3_valid) begin
        s4_re  <= rs_re[OUT_W-1:0];
        s4_im  <= rs_im[OUT_W-1:0];
        s4_sat <= {rs_re[OUT_W], rs_im[OUT_W]};
        s4_tag <= s3_tag;
      end
    end
  end

  assign bus.out_valid = s4_valid;
  assign bus.out_re    = s4_re;
  assign bus.out_im    = s4_im;
  assign bus.out_sat   = s4_sat;
  assign bus.out_tag   = s4_tag;

endmodule

// File: tb/tb_cmul_pipe.sv
// Directed bench for cmul_pipe: default build plus a SHIFT=4 / OUT_W=16 build
// for the rounding and narrow-saturation cases.
module tb_cmul_pipe;

  typedef struct {
    int a, b, c, d, conj, tag, re, im, sat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  cmul_pipe_if #(.DATA_W(16), .OUT_W(32), .TAG_W(4)) bus0 ();
  cmul_pipe_if #(.DATA_W(16), .OUT_W(16), .TAG_W(4)) bus1 ();

  cmul_pipe #(.DATA_W(16), .OUT_W(32), .SHIFT(0), .TAG_W(4)) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  cmul_pipe #(.DATA_W(16), .OUT_W(16), .SHIFT(4), .TAG_W(4)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input bit sel, input vec_t v);
    if (sel == 1'b0) begin
      bus0.in_valid = 1'b1;
      bus0.in_a     = 16'(v.a);
      bus0.in_b     = 16'(v.b);
      bus0.in_c     = 16'(v.c);
      bus0.in_d     = 16'(v.d);
      bus0.in_conj  = v.conj[0];
      bus0.in_tag   = 4'(v.tag);
    end else begin
      bus1.in_valid = 1'b1;
      bus1.in_a     = 16'(v.a);
      bus1.in_b     = 16'(v.b);
      bus1.in_c     = 16'(v.c);
      bus1.in_d     = 16'(v.d);
      bus1.in_conj  = v.conj[0];
      bus1.in_tag   = 4'(v.tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus0.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset out_valid: got %b expected 0", bus0.out_valid);
    end
    vectors++;
    if (bus0.out_re !== 32'sd0 || bus0.out_im !== 32'sd0) begin
      miscompares++; $display("[TB] FAIL reset data: got re=%0d im=%0d expected 0 0", bus0.out_re, bus0.out_im);
    end
    vectors++;
    if (bus0.out_sat !== 2'b00 || bus0.out_tag !== 4'h0) begin
      miscompares++; $display("[TB] FAIL reset sat/tag: got %b/%h expected 00/0", bus0.out_sat, bus0.out_tag);
    end
    vectors++;
    if (bus0.in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset in_ready: got %b expected 1", bus0.in_ready);
    end
    vectors++;
    if (bus1.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset dut1 out_valid: got %b expected 0", bus1.out_valid);
    end
    rst_n = 1'b1;
  endtask

  // Operands 3+j4 and 5-j2: plain product (23, 14) then conjugate (7, 26).
  task automatic test_product();
    vec_t v[2];
    v[0] = '{3, 4, 5, -2, 0, 10, 23, 14, 0};
    v[1] = '{3, 4, 5, -2, 1, 3, 7, 26, 0};
    for (int t = 0; t < 2 + 4; t++) begin
      vectors++;
      if (t < 4) begin
        if (bus0.out_valid !== 1'b0) begin
          miscompares++; $display("[TB] FAIL product early valid t=%0d: got %b expected 0", t, bus0.out_valid);
        end
      end else begin
        if (bus0.out_valid !== 1'b1 || bus0.out_re !== 32'(v[t-4].re) || bus0.out_im !== 32'(v[t-4].im)
            || bus0.out_sat !== 2'(v[t-4].sat) || bus0.out_tag !== 4'(v[t-4].tag)) begin
          miscompares++;
          $display("[TB] FAIL product[%0d]: got v=%b re=%0d im=%0d sat=%b tag=%h expected v=1 re=%0d im=%0d sat=%0d tag=%0d",
                   t-4, bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat, bus0.out_tag,
                   v[t-4].re, v[t-4].im, v[t-4].sat, v[t-4].tag);
        end
      end
      if (t < 2) applyStimulus(1'b0, v[t]);
      else bus0.in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[16];
    for (int i = 0; i < 16; i++) v[i] = '{3, 4, 5, -2, 0, i, 23, 14, 0};
    for (int t = 0; t < 16 + 4; t++) begin
      if (t >= 4) begin
        vectors++;
        if (bus0.out_valid !== 1'b1 || bus0.out_tag !== 4'(v[t-4].tag)) begin
          miscompares++;
          $display("[TB] FAIL b2b valid/tag[%0d]: got v=%b tag=%h expected v=1 tag=%0d",
                   t-4, bus0.out_valid, bus0.out_tag, v[t-4].tag);
        end
        vectors++;
        if (bus0.out_re !== 32'(v[t-4].re) || bus0.out_im !== 32'(v[t-4].im)) begin
          miscompares++;
          $display("[TB] FAIL b2b data[%0d]: got re=%0d im=%0d expected re=%0d im=%0d",
                   t-4, bus0.out_re, bus0.out_im, v[t-4].re, v[t-4].im);
        end
      end
      if (t < 16) applyStimulus(1'b0, v[t]);
      else bus0.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    vectors++;
    if (bus0.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL b2b drained valid: got %b expected 0", bus0.out_valid);
    end
  endtask

  task automatic test_saturation();
    vec_t v[2];
    v[0] = '{-32768, -32768, -32768, -32768, 1, 1, 2147483647, 0, 2};
    v[1] = '{-32768, -32768, -32768, 32767, 0, 2, 2147450880, 32768, 0};
    for (int t = 0; t < 2 + 4; t++) begin
      if (t >= 4) begin
        vectors++;
        if (bus0.out_valid !== 1'b1 || bus0.out_re !== 32'(v[t-4].re) || bus0.out_im !== 32'(v[t-4].im)
            || bus0.out_sat !== 2'(v[t-4].sat)) begin
          miscompares++;
          $display("[TB] FAIL saturation[%0d]: got v=%b re=%0d im=%0d sat=%b expected v=1 re=%0d im=%0d sat=%0d",
                   t-4, bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_sat,
                   v[t-4].re, v[t-4].im, v[t-4].sat);
        end
      end
      if (t < 2) applyStimulus(1'b0, v[t]);
      else bus0.in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // SHIFT=4, OUT_W=16: half-up rounding at +/- boundaries and 16-bit clamping.
  task automatic test_rounding();
    vec_t v[9];
    v[0] = '{3, 0, 3, 0, 0, 1, 1, 0, 0};
    v[1] = '{5, 0, 3, 0, 0, 2, 1, 0, 0};
    v[2] = '{-3, 0, 3, 0, 0, 3, -1, 0, 0};
    v[3] = '{-9, 0, 1, 0, 0, 4, -1, 0, 0};
    v[4] = '{7, 0, 1, 0, 0, 5, 0, 0, 0};
    v[5] = '{-8, 0, 1, 0, 0, 6, 0, 0, 0};
    v[6] = '{0, 4, 4, 0, 0, 7, 0, 1, 0};
    v[7] = '{-32768, 0, -32768, 0, 0, 8, 32767, 0, 2};
    v[8] = '{-32768, 0, 32767, 0, 0, 9, -32768, 0, 2};
    for (int t = 0; t < 9 + 4; t++) begin
      if (t >= 4) begin
        vectors++;
        if (bus1.out_valid !== 1'b1 || bus1.out_re !== 16'(v[t-4].re) || bus1.out_im !== 16'(v[t-4].im)
            || bus1.out_sat !== 2'(v[t-4].sat) || bus1.out_tag !== 4'(v[t-4].tag)) begin
          miscompares++;
          $display("[TB] FAIL rounding[%0d]: got v=%b re=%0d im=%0d sat=%b tag=%h expected v=1 re=%0d im=%0d sat=%0d tag=%0d",
                   t-4, bus1.out_valid, bus1.out_re, bus1.out_im, bus1.out_sat, bus1.out_tag,
                   v[t-4].re, v[t-4].im, v[t-4].sat, v[t-4].tag);
        end
      end
      if (t < 9) applyStimulus(1'b1, v[t]);
      else bus1.in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Sample n carries a=n, b=1, c=2, d=3 -> re = 2n-3, im = 3n+2, tag = n mod 16.
  task automatic test_backpressure();
    int            sent, recv;
    bit            stalled;
    bit            feeding;
    logic [31:0]   hold_re;
    logic [3:0]    hold_tag;
    vec_t          v;
    sent = 0; recv = 0; stalled = 1'b0; hold_re = '0; hold_tag = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      vectors++;
      if (bus0.in_ready !== ~(bus0.out_valid & ~bus0.out_ready)) begin
        miscompares++;
        $display("[TB] FAIL bp in_ready cyc=%0d: got %b expected %b", cyc, bus0.in_ready,
                 ~(bus0.out_valid & ~bus0.out_ready));
      end
      if (stalled) begin
        vectors++;
        if (bus0.out_valid !== 1'b1 || bus0.out_re !== hold_re || bus0.out_tag !== hold_tag) begin
          miscompares++;
          $display("[TB] FAIL bp hold cyc=%0d: got v=%b re=%0d tag=%h expected v=1 re=%0d tag=%h",
                   cyc, bus0.out_valid, bus0.out_re, bus0.out_tag, $signed(hold_re), hold_tag);
        end
      end
      feeding = (cyc < 250);
      if (feeding) begin
        bus0.out_ready = ($urandom_range(0, 9) < 3);
        v = '{sent, 1, 2, 3, 0, sent % 16, 2 * sent - 3, 3 * sent + 2, 0};
        applyStimulus(1'b0, v);
      end else begin
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b0;
      end
      #1;
      if (bus0.in_valid && bus0.in_ready) sent++;
      if (bus0.out_valid && bus0.out_ready) begin
        vectors++;
        if (bus0.out_tag !== 4'(recv % 16) || bus0.out_re !== 32'(2 * recv - 3)
            || bus0.out_im !== 32'(3 * recv + 2)) begin
          miscompares++;
          $display("[TB] FAIL bp scoreboard #%0d: got tag=%h re=%0d im=%0d expected tag=%0d re=%0d im=%0d",
                   recv, bus0.out_tag, bus0.out_re, bus0.out_im, recv % 16, 2 * recv - 3, 3 * recv + 2);
        end
        recv++;
      end
      stalled  = bus0.out_valid && !bus0.out_ready;
      hold_re  = bus0.out_re;
      hold_tag = bus0.out_tag;
      @(posedge clk); #1;
    end
    vectors++;
    if (recv != sent || sent < 20) begin
      miscompares++;
      $display("[TB] FAIL bp count: got received=%0d expected %0d (sent, at least 20)", recv, sent);
    end
  endtask

  task automatic test_reset_midstream();
    vec_t v;
    bus0.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      v = '{t + 1, 1, 1, 1, 0, t + 1, 0, 0, 0};
      applyStimulus(1'b0, v);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    bus0.in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus0.out_valid !== 1'b0 || bus0.out_re !== 32'sd0 || bus0.out_im !== 32'sd0
        || bus0.out_tag !== 4'h0 || bus0.out_sat !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL midreset flush: got v=%b re=%0d im=%0d tag=%h sat=%b expected all 0",
               bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_tag, bus0.out_sat);
    end
    vectors++;
    if (bus0.in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL midreset in_ready: got %b expected 1", bus0.in_ready);
    end
    rst_n = 1'b1;
    v = '{2, 3, 4, 5, 0, 12, -7, 22, 0};
    applyStimulus(1'b0, v);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      vectors++;
      if (bus0.out_valid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL midreset ghost t=%0d: got valid=%b tag=%h expected 0", t, bus0.out_valid, bus0.out_tag);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (bus0.out_valid !== 1'b1 || bus0.out_tag !== 4'hC || bus0.out_re !== -32'sd7 || bus0.out_im !== 32'sd22) begin
      miscompares++;
      $display("[TB] FAIL midreset new sample: got v=%b tag=%h re=%0d im=%0d expected v=1 tag=c re=-7 im=22",
               bus0.out_valid, bus0.out_tag, bus0.out_re, bus0.out_im);
    end
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus0.out_valid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL midreset tail t=%0d: got valid=%b tag=%h expected 0", t, bus0.out_valid, bus0.out_tag);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_c = '0; bus0.in_d = '0;
    bus0.in_conj  = 1'b0; bus0.in_tag = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_c = '0; bus1.in_d = '0;
    bus1.in_conj  = 1'b0; bus1.in_tag = '0; bus1.out_ready = 1'b1;

    test_reset();
    test_product();
    test_back_to_back();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_midstream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
